// File: rtl/md_lr_seq_ctrl.sv
// md_lr_seq_ctrl: run sequencer between a host particle stream and md_lr_top.
// Each run loads num_p particle records into particle memory, then drains the
// returned force records to the host. Record counts, flast placement and a
// stalled datapath are checked, and the status is reported.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start, abort, num_p        run control; num_p latched on an accepted start
//   in_valid/in_ready/in_data  host particle stream (passed through in LOAD)
//   pvalid/pready/paddr/pwe/pwdata/plast  particle memory write interface
//   fvalid/fready/fdata/flast  force records from the datapath
//   out_valid/out_ready/out_data/out_last host force stream (passed through in DRAIN)
//   busy, done                 run status (busy in LOAD/DRAIN, done one-cycle pulse)
//   err_timeout, err_count     sticky errors, cleared by abort or a new start
//   p_cnt, f_cnt               records transferred this run
module md_lr_seq_ctrl #(
   parameter int unsigned PADDRW = 15,
   parameter int unsigned PDATAW = 128,
   parameter int unsigned FDATAW = 96,
   parameter int unsigned TOW    = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [PADDRW:0]   num_p,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PDATAW-1:0] in_data,
   input  logic              pready,
   output logic              pvalid,
   output logic [PADDRW-1:0] paddr,
   output logic              pwe,
   output logic [PDATAW-1:0] pwdata,
   output logic              plast,
   input  logic              fvalid,
   output logic              fready,
   input  logic [FDATAW-1:0] fdata,
   input  logic              flast,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [FDATAW-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              err_timeout,
   output logic              err_count,
   output logic [PADDRW:0]   p_cnt,
   output logic [PADDRW:0]   f_cnt
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StLoad  = 3'd1;
   localparam logic [2:0] StDrain = 3'd2;
   localparam logic [2:0] StDone  = 3'd3;
   localparam logic [2:0] StErr   = 3'd4;

   localparam logic [PADDRW:0] CntOne = 1;
   localparam logic [TOW-1:0]  ToOne  = 1;

   logic [2:0]        state_q, state_d;
   logic [PADDRW:0]   num_p_q, num_p_d;
   logic [PADDRW:0]   p_cnt_q, p_cnt_d;
   logic [PADDRW:0]   f_cnt_q, f_cnt_d;
   logic [TOW-1:0]    to_q, to_d, to_inc;
   logic              err_to_q, err_to_d;
   logic              err_cnt_q, err_cnt_d;

   logic              in_load, in_drain;
   logic              p_xfer, f_xfer;
   logic [PADDRW:0]   last_idx;
   logic              f_at_last;

   assign in_load   = (state_q == StLoad);
   assign in_drain  = (state_q == StDrain);
   assign last_idx  = num_p_q - CntOne;
   assign f_at_last = (f_cnt_q == last_idx);
   assign to_inc    = to_q + ToOne;

   // Zero-latency pass-through, gated by state so idle outputs are all zero.
   assign pvalid    = in_load & in_valid;
   assign in_ready  = in_load & pready;
   assign pwe       = pvalid;
   assign pwdata    = in_load ? in_data : '0;
   assign paddr     = in_load ? p_cnt_q[PADDRW-1:0] : '0;
   assign plast     = in_load & (p_cnt_q == last_idx);
   assign p_xfer    = pvalid & pready;

   assign out_valid = in_drain & fvalid;
   assign fready    = in_drain & out_ready;
   assign out_data  = in_drain ? fdata : '0;
   assign out_last  = in_drain & flast;
   assign f_xfer    = out_valid & out_ready;

   // Decoded from the state register only, so no combinational glitches.
   assign busy        = in_load | in_drain;
   assign done        = (state_q == StDone);
   assign err_timeout = err_to_q;
   assign err_count   = err_cnt_q;
   assign p_cnt       = p_cnt_q;
   assign f_cnt       = f_cnt_q;

   always_comb begin
      state_d   = state_q;
      num_p_d   = num_p_q;
      p_cnt_d   = p_cnt_q;
      f_cnt_d   = f_cnt_q;
      to_d      = to_q;
      err_to_d  = err_to_q;
      err_cnt_d = err_cnt_q;

      if (abort) begin
         // Abort overrides any same-cycle transfer or start.
         state_d   = StIdle;
         p_cnt_d   = '0;
         f_cnt_d   = '0;
         to_d      = '0;
         err_to_d  = 1'b0;
         err_cnt_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start && (num_p != '0)) begin
                  state_d   = StLoad;
                  num_p_d   = num_p;
                  p_cnt_d   = '0;
                  f_cnt_d   = '0;
                  to_d      = '0;
                  err_to_d  = 1'b0;
                  err_cnt_d = 1'b0;
               end
            end
            StLoad: begin
               if (p_xfer) begin
                  p_cnt_d = p_cnt_q + CntOne;
                  if (plast) state_d = StDrain;
               end
            end
            StDrain: begin
               if (f_xfer) begin
                  f_cnt_d = f_cnt_q + CntOne;
                  to_d    = '0;
                  if (flast && f_at_last) begin
                     state_d = StDone;
                  end else if (flast || f_at_last) begin
                     // flast early, or missing on the final record.
                     err_cnt_d = 1'b1;
                     state_d   = StErr;
                  end
               end else if (!fvalid) begin
                  // Host backpressure (fvalid with out_ready low) holds the count.
                  to_d = to_inc;
                  if (&to_inc) begin
                     err_to_d = 1'b1;
                     state_d  = StErr;
                  end
               end
            end
            StDone: state_d = StIdle;
            StErr:  state_d = StErr;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         num_p_q   <= '0;
         p_cnt_q   <= '0;
         f_cnt_q   <= '0;
         to_q      <= '0;
         err_to_q  <= 1'b0;
         err_cnt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         num_p_q   <= num_p_d;
         p_cnt_q   <= p_cnt_d;
         f_cnt_q   <= f_cnt_d;
         to_q      <= to_d;
         err_to_q  <= err_to_d;
         err_cnt_q <= err_cnt_d;
      end
   end

endmodule
